// File: rtl/aes_pkg.sv
// Shared AES definitions: controller state encoding, block/round constants and
// the byte-level S-box and xtime helpers used by the round datapath.
package aes_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRound = 2'd1,
    StFinal = 2'd2,
    StDone  = 2'd3
  } aes_state_e;

  localparam int unsigned AES_BLK_W  = 128;
  localparam int unsigned AES_NR_128 = 10;
  localparam int unsigned AES_NR_192 = 12;
  localparam int unsigned AES_NR_256 = 14;

  // Entry for input byte 0 sits in the top byte.
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [10:0] base;
    base = {~x, 3'b000};
    return SBOX_TABLE[base +: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/aes_enc_round.sv
// Combinational AES encryption round: SubBytes, ShiftRows, optional MixColumns,
// AddRoundKey. final_i bypasses MixColumns for the last round.
module aes_enc_round
  import aes_pkg::*;
(
  input  logic [AES_BLK_W-1:0] state_i,
  input  logic [AES_BLK_W-1:0] key_i,
  input  logic                 final_i,
  output logic [AES_BLK_W-1:0] state_o
);

  // Byte i is column i/4, row i%4.
  logic [7:0] sb [16];
  logic [7:0] sr [16];
  logic [7:0] mc [16];

  always_comb begin
    for (int i = 0; i < 16; i++) begin
      sb[i] = sbox(state_i[127-8*i -: 8]);
    end
  end

  always_comb begin
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        sr[4*c+r] = sb[4*((c+r)%4)+r];
      end
    end
  end

  always_comb begin
    for (int c = 0; c < 4; c++) begin
      mc[4*c+0] = xtime(sr[4*c]) ^ xtime(sr[4*c+1]) ^ sr[4*c+1] ^ sr[4*c+2] ^ sr[4*c+3];
      mc[4*c+1] = sr[4*c] ^ xtime(sr[4*c+1]) ^ xtime(sr[4*c+2]) ^ sr[4*c+2] ^ sr[4*c+3];
      mc[4*c+2] = sr[4*c] ^ sr[4*c+1] ^ xtime(sr[4*c+2]) ^ xtime(sr[4*c+3]) ^ sr[4*c+3];
      mc[4*c+3] = xtime(sr[4*c]) ^ sr[4*c] ^ sr[4*c+1] ^ sr[4*c+2] ^ xtime(sr[4*c+3]);
    end
  end

  always_comb begin
    state_o = '0;
    for (int i = 0; i < 16; i++) begin
      state_o[127-8*i -: 8] = (final_i ? sr[i] : mc[i]) ^ key_i[127-8*i -: 8];
    end
  end

endmodule

// File: rtl/aes_enc_round_ctrl.sv
// Iterative AES encryption sequencer: owns the state register, steps the shared
// round datapath once per clock and handshakes plaintext in / ciphertext out.
module aes_enc_round_ctrl
  import aes_pkg::*;
#(
  parameter int unsigned NR     = AES_NR_128,
  parameter int unsigned KIDX_W = 4
) (
  input  logic                 i_Clk,
  input  logic                 i_Rst_n,
  input  logic [AES_BLK_W-1:0] i_Din,
  input  logic                 i_Valid,
  output logic                 o_Ready,
  output logic [KIDX_W-1:0]    o_Key_Idx,
  input  logic [AES_BLK_W-1:0] i_Round_Key,
  input  logic                 i_Key_Ready,
  output logic [AES_BLK_W-1:0] o_Dout,
  output logic                 o_Valid,
  input  logic                 i_Ready,
  output logic                 o_Busy
);

  aes_state_e             st_q, st_d;
  logic [KIDX_W-1:0]      rnd_q, rnd_d;
  logic [AES_BLK_W-1:0]   state_q, state_d;
  logic [AES_BLK_W-1:0]   round_out;
  logic                   accept;

  aes_enc_round u_round (
    .state_i (state_q),
    .key_i   (i_Round_Key),
    .final_i (st_q == StFinal),
    .state_o (round_out)
  );

  assign o_Ready = i_Key_Ready && ((st_q == StIdle) || ((st_q == StDone) && i_Ready));
  assign accept  = i_Valid && o_Ready;
  assign o_Valid = (st_q == StDone);
  assign o_Busy  = (st_q == StRound) || (st_q == StFinal);
  assign o_Dout  = o_Valid ? state_q : '0;

  // Key index is decoded from registered state only, so the key store sees no glitches.
  always_comb begin
    o_Key_Idx = '0;
    unique case (st_q)
      StRound: o_Key_Idx = rnd_q;
      StFinal: o_Key_Idx = KIDX_W'(NR);
      default: o_Key_Idx = '0;
    endcase
  end

  always_comb begin
    st_d    = st_q;
    rnd_d   = rnd_q;
    state_d = state_q;
    unique case (st_q)
      StIdle: begin
        if (accept) begin
          state_d = i_Din ^ i_Round_Key;
          rnd_d   = KIDX_W'(1);
          st_d    = StRound;
        end
      end
      StRound: begin
        state_d = round_out;
        rnd_d   = rnd_q + 1'b1;
        if (rnd_q == KIDX_W'(NR - 1)) st_d = StFinal;
      end
      StFinal: begin
        state_d = round_out;
        st_d    = StDone;
      end
      StDone: begin
        if (accept) begin
          state_d = i_Din ^ i_Round_Key;
          rnd_d   = KIDX_W'(1);
          st_d    = StRound;
        end else if (i_Ready) begin
          rnd_d = '0;
          st_d  = StIdle;
        end
      end
      default: st_d = StIdle;
    endcase
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      st_q    <= StIdle;
      rnd_q   <= '0;
      state_q <= '0;
    end else begin
      st_q    <= st_d;
      rnd_q   <= rnd_d;
      state_q <= state_d;
    end
  end

endmodule
